semiauto_nav: RTL and testbench
===============================

// Module: semiauto_nav
// PURPOSE
//  Parametrised semi-auto driving controller; successor to the fixed-timing semi-auto FSM.
//  Owns its state register, follows the track, stops at crossroads and executes queued
//  driver commands. Turn, U-turn and cooldown durations are parameters. Drives motion
//  code to the chassis mux; enabled by top level when powered and in semi-auto mode.
// PARAMETERS
//  TICK_DIV     2000000  sys_clk cycles per timing tick (20 ms @ 100 MHz), >=2
//  CNT_W        16       width of tick counter; must hold max(TURN,UTURN,COOL)_TICKS
//  TURN_TICKS   100      ticks for a 90-degree turn, >=1
//  UTURN_TICKS  200      ticks for a U-turn (back command), >=1
//  COOL_TICKS   50       ticks of forced forward motion after a manoeuvre, >=1
// PORTS
//  sys_clk       in   1  system clock, single domain
//  rst           in   1  synchronous reset, active-high
//  en            in   1  1 = powered and semi-auto mode active
//  detector      in   4  line/obstacle sensors; crossroad = d[0] | ~d[1] | ~d[2]
//  cmd_straight  in   1  driver button, level; rising edge = command
//  cmd_left      in   1  driver button, level; rising edge = command
//  cmd_right     in   1  driver button, level; rising edge = command
//  cmd_back      in   1  driver button, level; rising edge = command (U-turn)
//  move          out  4  0001 fwd, 0100 left, 1000 right, 0000 stop; registered
//  state         out  3  000 IDLE, 001 FWD, 010 WAIT, 011 TURN, 100 COOL; registered
//  cmd_pending   out  1  a queued command is waiting to be consumed
//  turn_done     out  1  one-cycle pulse on the cycle state leaves TURN
// BEHAVIOUR
//  Reset: state=IDLE, move=0000, cmd_pending=0, turn_done=0, counters/prescaler/edge regs=0.
//  crossroad registered each cycle; detector change affects state 2 edges later.
//  Cmd capture: prev-value regs per button; rise = in & ~prev. Priority straight > back >
//   left > right; left+right rising together (no straight/back) ignored. Valid rise writes
//   pending {code, uturn}, overwriting older pending (latest wins). Capture active in all
//   states while en=1, including FWD/TURN/COOL (pre-queuing).
//  Timing: on every state change prescaler and tick counter clear. Prescaler counts
//   0..TICK_DIV-1; tick when it equals TICK_DIV-1, counter +1 (saturates at all-ones).
//   Timed state of N ticks exits on the edge where tick fires with counter==N-1:
//   dwell exactly N*TICK_DIV cycles.
//  FSM (next-state registered; move updates on same edge as state):
//   IDLE: move=stop; en=1 -> WAIT.
//   FWD : move=fwd; crossroad=1 -> WAIT.
//   WAIT: move=stop; pending straight -> COOL (fwd); left -> TURN (left);
//         right -> TURN (right); back -> TURN (left, uturn=1); no pending -> stay.
//         Consumption clears cmd_pending, unless a new valid rise lands on that same
//         cycle: then new command becomes pending (never lost).
//   TURN: move holds direction; after TURN_TICKS (UTURN_TICKS if uturn) -> COOL, turn_done=1.
//   COOL: move=fwd (clears crossroad marking); after COOL_TICKS -> FWD.
//  en=0 in any state: next edge state=IDLE, move=stop, pending cleared, counters cleared;
//   overrides all other transitions; mid-turn abort does not pulse turn_done.
//  rst overrides en. Undefined state encodings recover to IDLE.
// TESTING (bench params: TICK_DIV=4, TURN=3, UTURN=6, COOL=2)
//  rst then en=1, detector=4'b0110 -> IDLE, WAIT next edge; no cmd -> WAIT, move=0000 held.
//  WAIT, pulse cmd_left -> cmd_pending=1, next edge TURN move=0100; 12 cycles later COOL
//   move=0001, turn_done=1 for 1 cycle; 8 cycles later FWD.
//  FWD, detector 0110->0111 -> state=WAIT, move=0000 exactly 2 edges after change.
//  Pulse cmd_right during FWD, then crossroad -> WAIT 1 cycle, TURN move=1000 (queued cmd).
//  WAIT, cmd_back pulse -> TURN move=0100 for 24 cycles; left+right together -> no pending.
//  Mid-TURN drop en -> next edge IDLE, move=0000, cmd_pending=0, turn_done stays 0.

Source files
------------

// File: rtl/semiauto_nav_if.sv
// Bundles the semi-auto controller's mode, sensor, button and motion signals.
// The master side is the top level or bench; the slave side is the controller.
interface semiauto_nav_if;
    logic       en;
    logic [3:0] detector;
    logic       cmd_straight;
    logic       cmd_left;
    logic       cmd_right;
    logic       cmd_back;
    logic [3:0] move;
    logic [2:0] state;
    logic       cmd_pending;
    logic       turn_done;

    modport master (
        output en, detector, cmd_straight, cmd_left, cmd_right, cmd_back,
        input  move, state, cmd_pending, turn_done
    );

    modport slave (
        input  en, detector, cmd_straight, cmd_left, cmd_right, cmd_back,
        output move, state, cmd_pending, turn_done
    );
endinterface

// File: rtl/semiauto_nav.sv
// Semi-auto driving controller: follows the track, stops at crossroads and runs the
// latest queued driver command with tick-timed turn, U-turn and cooldown phases.
module semiauto_nav #(
    parameter int unsigned TICK_DIV    = 2000000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TURN_TICKS  = 100,
    parameter int unsigned UTURN_TICKS = 200,
    parameter int unsigned COOL_TICKS  = 50
) (
    input  logic           sys_clk,
    input  logic           rst,
    semiauto_nav_if.slave  bus
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PrescLast = PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   TurnLast  = CNT_W'(TURN_TICKS - 1);
    localparam logic [CNT_W-1:0]   UturnLast = CNT_W'(UTURN_TICKS - 1);
    localparam logic [CNT_W-1:0]   CoolLast  = CNT_W'(COOL_TICKS - 1);

    localparam logic [3:0] MoveStop  = 4'b0000;
    localparam logic [3:0] MoveFwd   = 4'b0001;
    localparam logic [3:0] MoveLeft  = 4'b0100;
    localparam logic [3:0] MoveRight = 4'b1000;

    typedef enum logic [2:0] {
        StIdle = 3'b000,
        StFwd  = 3'b001,
        StWait = 3'b010,
        StTurn = 3'b011,
        StCool = 3'b100
    } state_e;

    typedef enum logic [1:0] {
        CmdStraight = 2'd0,
        CmdLeft     = 2'd1,
        CmdRight    = 2'd2
    } cmd_e;

    state_e             state_q, state_d;
    logic [3:0]         move_q, move_d;
    logic               uturn_q, uturn_d;
    logic               turn_done_q, turn_done_d;
    logic               cross_q, cross_d;
    logic [3:0]         prev_q, prev_d;
    logic               pend_valid_q, pend_valid_d;
    cmd_e               pend_code_q, pend_code_d;
    logic               pend_uturn_q, pend_uturn_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [3:0] buttons;
    logic [3:0] rise;
    logic       cmd_valid;
    cmd_e       cmd_code;
    logic       cmd_uturn;
    logic       consume;
    logic       tick;
    logic       unused_det;

    assign unused_det = bus.detector[3];
    // Bit order: {straight, back, left, right}, highest priority first.
    assign buttons = {bus.cmd_straight, bus.cmd_back, bus.cmd_left, bus.cmd_right};
    assign rise    = buttons & ~prev_q;
    assign tick    = (presc_q == PrescLast);

    always_comb begin
        cross_d   = bus.detector[0] | ~bus.detector[1] | ~bus.detector[2];
        prev_d    = buttons;
        cmd_valid = 1'b0;
        cmd_code  = CmdStraight;
        cmd_uturn = 1'b0;
        if (rise[3]) begin
            cmd_valid = 1'b1;
        end else if (rise[2]) begin
            cmd_valid = 1'b1;
            cmd_code  = CmdLeft;
            cmd_uturn = 1'b1;
        end else if (rise[1] && !rise[0]) begin
            cmd_valid = 1'b1;
            cmd_code  = CmdLeft;
        end else if (rise[0] && !rise[1]) begin
            cmd_valid = 1'b1;
            cmd_code  = CmdRight;
        end
    end

    always_comb begin
        state_d     = state_q;
        move_d      = move_q;
        uturn_d     = uturn_q;
        turn_done_d = 1'b0;
        consume     = 1'b0;
        if (!bus.en) begin
            state_d = StIdle;
            move_d  = MoveStop;
            uturn_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StWait;
                    move_d  = MoveStop;
                end
                StFwd: begin
                    move_d = MoveFwd;
                    if (cross_q) begin
                        state_d = StWait;
                        move_d  = MoveStop;
                    end
                end
                StWait: begin
                    move_d = MoveStop;
                    if (pend_valid_q) begin
                        consume = 1'b1;
                        case (pend_code_q)
                            CmdStraight: begin
                                state_d = StCool;
                                move_d  = MoveFwd;
                            end
                            CmdLeft: begin
                                state_d = StTurn;
                                move_d  = MoveLeft;
                                uturn_d = pend_uturn_q;
                            end
                            CmdRight: begin
                                state_d = StTurn;
                                move_d  = MoveRight;
                                uturn_d = 1'b0;
                            end
                            default: consume = 1'b0;
                        endcase
                    end
                end
                StTurn: begin
                    if (tick && (cnt_q == (uturn_q ? UturnLast : TurnLast))) begin
                        state_d     = StCool;
                        move_d      = MoveFwd;
                        turn_done_d = 1'b1;
                    end
                end
                StCool: begin
                    move_d = MoveFwd;
                    if (tick && (cnt_q == CoolLast)) begin
                        state_d = StFwd;
                    end
                end
                default: begin
                    state_d = StIdle;
                    move_d  = MoveStop;
                end
            endcase
        end
    end

    // A fresh rise on the consuming cycle replaces the consumed command rather than being lost.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
        pend_uturn_d = pend_uturn_q;
        if (!bus.en) begin
            pend_valid_d = 1'b0;
            pend_code_d  = CmdStraight;
            pend_uturn_d = 1'b0;
        end else if (cmd_valid) begin
            pend_valid_d = 1'b1;
            pend_code_d  = cmd_code;
            pend_uturn_d = cmd_uturn;
        end else if (consume) begin
            pend_valid_d = 1'b0;
        end
    end

    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        if (!bus.en || (state_d != state_q)) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= StIdle;
            move_q       <= MoveStop;
            uturn_q      <= 1'b0;
            turn_done_q  <= 1'b0;
            cross_q      <= 1'b0;
            prev_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_code_q  <= CmdStraight;
            pend_uturn_q <= 1'b0;
            presc_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            move_q       <= move_d;
            uturn_q      <= uturn_d;
            turn_done_q  <= turn_done_d;
            cross_q      <= cross_d;
            prev_q       <= prev_d;
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
            pend_uturn_q <= pend_uturn_d;
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.move        = move_q;
    assign bus.state       = state_q;
    assign bus.cmd_pending = pend_valid_q;
    assign bus.turn_done   = turn_done_q;

endmodule

// File: tb/tb_semiauto_nav.sv
// Scoreboard bench for semiauto_nav: each stimulus step queues the outputs expected on
// specific later cycles; a negedge monitor pops and compares them.
module tb_semiauto_nav;

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_FWD  = 3'b001;
    localparam logic [2:0] S_WAIT = 3'b010;
    localparam logic [2:0] S_TURN = 3'b011;
    localparam logic [2:0] S_COOL = 3'b100;
    localparam logic [3:0] M_STOP = 4'b0000;
    localparam logic [3:0] M_FWD  = 4'b0001;
    localparam logic [3:0] M_LEFT = 4'b0100;
    localparam logic [3:0] M_RGHT = 4'b1000;

    typedef struct {
        int         cyc;
        string      tag;
        logic [2:0] st;
        logic [3:0] mv;
        logic       pend;
        logic       td;
    } exp_t;

    logic   clk;
    logic   rst;
    int     cyc;
    int     n_checks;
    int     n_errors;
    exp_t   sb_q[$];
    exp_t   mon_e;

    semiauto_nav_if nav_if ();

    semiauto_nav #(
        .TICK_DIV    (4),
        .CNT_W       (8),
        .TURN_TICKS  (3),
        .UTURN_TICKS (6),
        .COOL_TICKS  (2)
    ) dut (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (nav_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_at(input int dly, input string tag, input logic [2:0] st,
                             input logic [3:0] mv, input logic pend, input logic td);
        exp_t e;
        e.cyc  = cyc + dly;
        e.tag  = tag;
        e.st   = st;
        e.mv   = mv;
        e.pend = pend;
        e.td   = td;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            check_eq({mon_e.tag, ".cyc"},  8'(cyc),                8'(mon_e.cyc));
            check_eq({mon_e.tag, ".st"},   8'(nav_if.state),       8'(mon_e.st));
            check_eq({mon_e.tag, ".mv"},   8'(nav_if.move),        8'(mon_e.mv));
            check_eq({mon_e.tag, ".pend"}, 8'(nav_if.cmd_pending), 8'(mon_e.pend));
            check_eq({mon_e.tag, ".td"},   8'(nav_if.turn_done),   8'(mon_e.td));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end by 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks            = 0;
        n_errors            = 0;
        rst                 = 1'b1;
        nav_if.en           = 1'b0;
        nav_if.detector     = 4'b0110;
        nav_if.cmd_straight = 1'b0;
        nav_if.cmd_left     = 1'b0;
        nav_if.cmd_right    = 1'b0;
        nav_if.cmd_back     = 1'b0;

        // Reset, then IDLE -> WAIT, then WAIT holds with nothing queued (cyc 3).
        step(3);
        expect_at(0, "reset",     S_IDLE, M_STOP, 1'b0, 1'b0);
        expect_at(1, "idle2wait", S_WAIT, M_STOP, 1'b0, 1'b0);
        expect_at(5, "wait_hold", S_WAIT, M_STOP, 1'b0, 1'b0);
        rst       = 1'b0;
        nav_if.en = 1'b1;
        step(5);

        // Left turn: 12-cycle TURN, 8-cycle COOL (cyc 8).
        expect_at(1,  "l_pend",   S_WAIT, M_STOP, 1'b1, 1'b0);
        expect_at(2,  "l_turn",   S_TURN, M_LEFT, 1'b0, 1'b0);
        expect_at(13, "l_turnend", S_TURN, M_LEFT, 1'b0, 1'b0);
        expect_at(14, "l_cool",   S_COOL, M_FWD,  1'b0, 1'b1);
        expect_at(15, "l_tdone0", S_COOL, M_FWD,  1'b0, 1'b0);
        expect_at(21, "l_coolend", S_COOL, M_FWD, 1'b0, 1'b0);
        expect_at(22, "l_fwd",    S_FWD,  M_FWD,  1'b0, 1'b0);
        nav_if.cmd_left = 1'b1;
        step(1);
        nav_if.cmd_left = 1'b0;
        step(22);

        // Crossroad seen two edges after the detector change (cyc 31).
        expect_at(1, "x_fwd",  S_FWD,  M_FWD,  1'b0, 1'b0);
        expect_at(2, "x_wait", S_WAIT, M_STOP, 1'b0, 1'b0);
        nav_if.detector = 4'b0111;
        step(3);

        // Straight command goes through COOL back to FWD (cyc 34).
        expect_at(1,  "s_pend", S_WAIT, M_STOP, 1'b1, 1'b0);
        expect_at(2,  "s_cool", S_COOL, M_FWD,  1'b0, 1'b0);
        expect_at(9,  "s_cend", S_COOL, M_FWD,  1'b0, 1'b0);
        expect_at(10, "s_fwd",  S_FWD,  M_FWD,  1'b0, 1'b0);
        nav_if.detector     = 4'b0110;
        nav_if.cmd_straight = 1'b1;
        step(1);
        nav_if.cmd_straight = 1'b0;
        step(10);

        // Right pre-queued during FWD, executed after the crossroad stop (cyc 45).
        expect_at(1,  "r_preq",  S_FWD,  M_FWD,  1'b1, 1'b0);
        expect_at(4,  "r_wait",  S_WAIT, M_STOP, 1'b1, 1'b0);
        expect_at(5,  "r_turn",  S_TURN, M_RGHT, 1'b0, 1'b0);
        expect_at(16, "r_tend",  S_TURN, M_RGHT, 1'b0, 1'b0);
        expect_at(17, "r_cool",  S_COOL, M_FWD,  1'b0, 1'b1);
        expect_at(25, "r_fwd",   S_FWD,  M_FWD,  1'b0, 1'b0);
        expect_at(26, "r_wait2", S_WAIT, M_STOP, 1'b0, 1'b0);
        nav_if.cmd_right = 1'b1;
        step(1);
        nav_if.cmd_right = 1'b0;
        step(1);
        nav_if.detector = 4'b0111;
        step(25);

        // U-turn lasts 24 cycles; left+right together is ignored (cyc 72).
        expect_at(1,  "b_pend",  S_WAIT, M_STOP, 1'b1, 1'b0);
        expect_at(2,  "b_turn",  S_TURN, M_LEFT, 1'b0, 1'b0);
        expect_at(9,  "lr_none", S_TURN, M_LEFT, 1'b0, 1'b0);
        expect_at(13, "lr_none2", S_TURN, M_LEFT, 1'b0, 1'b0);
        expect_at(25, "b_tend",  S_TURN, M_LEFT, 1'b0, 1'b0);
        expect_at(26, "b_cool",  S_COOL, M_FWD,  1'b0, 1'b1);
        expect_at(34, "b_fwd",   S_FWD,  M_FWD,  1'b0, 1'b0);
        expect_at(35, "b_wait",  S_WAIT, M_STOP, 1'b0, 1'b0);
        nav_if.cmd_back = 1'b1;
        step(1);
        nav_if.cmd_back = 1'b0;
        step(7);
        nav_if.cmd_left  = 1'b1;
        nav_if.cmd_right = 1'b1;
        step(2);
        nav_if.cmd_left  = 1'b0;
        nav_if.cmd_right = 1'b0;
        step(26);

        // Abort mid-turn with a pre-queued command, then re-enable (cyc 108).
        expect_at(1,  "a_pend",  S_WAIT, M_STOP, 1'b1, 1'b0);
        expect_at(2,  "a_turn",  S_TURN, M_LEFT, 1'b0, 1'b0);
        expect_at(5,  "a_preq",  S_TURN, M_LEFT, 1'b1, 1'b0);
        expect_at(7,  "a_idle",  S_IDLE, M_STOP, 1'b0, 1'b0);
        expect_at(8,  "a_idle2", S_IDLE, M_STOP, 1'b0, 1'b0);
        expect_at(10, "a_rewait", S_WAIT, M_STOP, 1'b0, 1'b0);
        nav_if.cmd_left = 1'b1;
        step(1);
        nav_if.cmd_left = 1'b0;
        step(3);
        nav_if.cmd_right = 1'b1;
        step(1);
        nav_if.cmd_right = 1'b0;
        step(1);
        nav_if.en = 1'b0;
        step(3);
        nav_if.en = 1'b1;
        step(3);

        check_eq("sb_drained", 8'(sb_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
